// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Holds every downstream reset asserted for HOLD cycles after a reset
//   event, then releases the per-stage resets one at a time, DELAY cycles
//   apart, bit 0 first. A software request (sw_req) restarts the whole
//   sequence from any state.
//
// Ports
//   clk         input               clock
//   rstz        input               async active-low reset (deassertion pre-synchronized)
//   sw_req      input               synchronous software reset request, level, active-high
//   stage_rstz  output [NSTAGE-1:0] per-stage active-low resets, bit 0 released first
//   ready       output              all stages released
//   done        output              one-cycle pulse on entry to RUN
//   busy        output              sequence in progress (HOLD or REL)
module rst_sequencer #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned HOLD   = 8,
  parameter int unsigned DELAY  = 16
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic              sw_req,
  output logic [NSTAGE-1:0] stage_rstz,
  output logic              ready,
  output logic              done,
  output logic              busy
);

  localparam int unsigned CMAX = (HOLD > DELAY) ? HOLD : DELAY;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned IW   = $clog2(NSTAGE + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NSTAGE - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              ready_q, ready_d;
  logic              done_q,  done_d;
  logic              busy_q,  busy_d;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    if (sw_req) begin
      // Held request parks the block in HOLD with the counter pinned at 0.
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_REL;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REL: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            for (int unsigned i = 0; i < NSTAGE; i++) begin
              if (idx_q == IW'(i)) stage_d[i] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end
      endcase
    end

    // busy is registered alongside the state so it tracks state_q exactly.
    busy_d = (state_d != S_RUN);
  end

  assign stage_rstz = stage_q;
  assign ready      = ready_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rstz, sw_req;
  logic [2:0] stage_rstz;
  logic       ready, done, busy;

  logic       rstz1, sw_req1;
  logic [0:0] stage1;
  logic       ready1, done1, busy1;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  rst_sequencer #(.NSTAGE(3), .HOLD(8), .DELAY(16)) dut (
    .clk(clk), .rstz(rstz), .sw_req(sw_req),
    .stage_rstz(stage_rstz), .ready(ready), .done(done), .busy(busy)
  );

  rst_sequencer #(.NSTAGE(1), .HOLD(1), .DELAY(1)) dut1 (
    .clk(clk), .rstz(rstz1), .sw_req(sw_req1),
    .stage_rstz(stage1), .ready(ready1), .done(done1), .busy(busy1)
  );

  typedef struct {
    int         e;
    logic [2:0] st;
    logic       rdy;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int e, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, e, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic [2:0] st,
                         input logic rdy, input logic dn, input logic bsy);
    chk({tag, ".stage"}, e, {5'd0, stage_rstz}, {5'd0, st});
    chk({tag, ".ready"}, e, {7'd0, ready}, {7'd0, rdy});
    chk({tag, ".done"},  e, {7'd0, done},  {7'd0, dn});
    chk({tag, ".busy"},  e, {7'd0, busy},  {7'd0, bsy});
  endtask

  // Advance to just after posedge number e (edges counted from cur=0).
  task automatic step_to(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      step_to(tbl[i].e);
      chk_all(tag, tbl[i].e, tbl[i].st, tbl[i].rdy, tbl[i].dn, tbl[i].bsy);
    end
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstz = 1'b1;
    cur  = 0;
  endtask

  initial begin
    tbl[0] = '{e: 0,   st: 3'b000, rdy: 0, dn: 0, bsy: 1};
    tbl[1] = '{e: 23,  st: 3'b000, rdy: 0, dn: 0, bsy: 1};
    tbl[2] = '{e: 24,  st: 3'b001, rdy: 0, dn: 0, bsy: 1};
    tbl[3] = '{e: 39,  st: 3'b001, rdy: 0, dn: 0, bsy: 1};
    tbl[4] = '{e: 40,  st: 3'b011, rdy: 0, dn: 0, bsy: 1};
    tbl[5] = '{e: 55,  st: 3'b011, rdy: 0, dn: 0, bsy: 1};
    tbl[6] = '{e: 56,  st: 3'b111, rdy: 1, dn: 1, bsy: 0};
    tbl[7] = '{e: 57,  st: 3'b111, rdy: 1, dn: 0, bsy: 0};
    tbl[8] = '{e: 90,  st: 3'b111, rdy: 1, dn: 0, bsy: 0};

    rstz = 1'b0; sw_req = 1'b0;
    rstz1 = 1'b0; sw_req1 = 1'b0;
    #12;
    chk_all("reset", 0, 3'b000, 0, 0, 1);

    // Power-on sequence
    do_reset();
    run_table("por");

    // sw_req pulse in RUN, then restart from its falling edge
    @(negedge clk); sw_req = 1'b1;
    @(posedge clk); #1;
    chk_all("swrun", 1, 3'b000, 0, 0, 1);
    @(negedge clk); sw_req = 1'b0; cur = 0;
    run_table("swrun_rst");

    // sw_req held 10 cycles after stage0 released
    do_reset();
    step_to(30);
    chk_all("pre_hold", 30, 3'b001, 0, 0, 1);
    @(negedge clk); sw_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      chk_all("swheld", i, 3'b000, 0, 0, 1);
    end
    @(negedge clk); sw_req = 1'b0; cur = 0;
    run_table("swheld_rst");

    // Asynchronous rstz pulse between edges
    do_reset();
    step_to(45);
    chk_all("pre_async", 45, 3'b011, 0, 0, 1);
    #1 rstz = 1'b0;
    #1;
    chk_all("async", 45, 3'b000, 0, 0, 1);
    do_reset();
    run_table("async_rst");

    // Minimum configuration: NSTAGE=1, HOLD=1, DELAY=1
    @(negedge clk); rstz1 = 1'b1; cur = 0;
    step_to(1);
    chk("min.stage1", 1, {7'd0, stage1}, 8'd0);
    chk("min.ready1", 1, {7'd0, ready1}, 8'd0);
    chk("min.busy1",  1, {7'd0, busy1},  8'd1);
    step_to(2);
    chk("min.stage2", 2, {7'd0, stage1}, 8'd1);
    chk("min.ready2", 2, {7'd0, ready1}, 8'd1);
    chk("min.done2",  2, {7'd0, done1},  8'd1);
    chk("min.busy2",  2, {7'd0, busy1},  8'd0);
    step_to(3);
    chk("min.done3",  3, {7'd0, done1},  8'd0);
    step_to(10);
    chk("min.stage10", 10, {7'd0, stage1}, 8'd1);
    chk("min.ready10", 10, {7'd0, ready1}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NSTAGE, default 3: number of sequenced reset outputs; legal range 1..8.
REQ-002 Parameter HOLD, default 8: minimum cycles all outputs stay asserted after any reset event; legal >=1.
REQ-003 Parameter DELAY, default 16: cycles between consecutive stage releases; legal >=1.
REQ-004 Port clk  input  1: clock.
REQ-005 Port rstz  input  1: reset, asynchronous, active-low; deassertion arrives already synchronized to clk by the upstream reset synchronizer.
REQ-006 Port sw_req  input  1: synchronous software reset request, level-sensitive, active-high.
REQ-007 Port stage_rstz  output  NSTAGE: per-stage active-low resets; bit 0 released first.
REQ-008 Port ready  output  1: high when all stages are released.
REQ-009 Port done  output  1: single-cycle pulse on entry to RUN.
REQ-010 Port busy  output  1: high in HOLD or REL states.

Function
REQ-011 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-012 FSM states: HOLD, REL, RUN.
REQ-013 HOLD: cnt increments each cycle; when cnt==HOLD-1 -> REL, cnt<=0, idx<=0.
REQ-014 REL: cnt increments each cycle; when cnt==DELAY-1 -> stage_rstz[idx]<=1, cnt<=0, idx<=idx+1.
REQ-015 REL: the edge that releases stage NSTAGE-1 shall also set ready<=1, done<=1, and state<=RUN.
REQ-016 done shall be high exactly one cycle per RUN entry.
REQ-017 Release timing: stage k shall go high at clock edge HOLD+(k+1)*DELAY, counted from the first edge with rstz high (edge 1).
REQ-018 Released stages shall stay high until the next reset event; release order shall be strictly monotonic, bit 0 first.
REQ-019 sw_req=1 sampled in any state: next state HOLD, cnt<=0, idx<=0, stage_rstz<=0, ready<=0, done<=0.
REQ-020 sw_req held high shall keep the block in HOLD with cnt held at 0; the HOLD count starts on the first edge with sw_req=0.
REQ-021 sw_req during HOLD or REL shall restart the full sequence; already-released stages re-assert at that edge.
REQ-022 busy shall be 1 in HOLD and REL and 0 in RUN.
REQ-023 cnt width shall be clog2(max(HOLD,DELAY)+1) bits; idx width shall be clog2(NSTAGE+1) bits; neither counter wraps.
REQ-024 NSTAGE=1: the single stage and ready shall rise at edge HOLD+DELAY.

Reset
REQ-025 rstz low shall immediately (asynchronously) force state=HOLD, cnt=0, idx=0, stage_rstz=0, ready=0, done=0, busy=1.
REQ-026 rstz assertion mid-sequence or in RUN shall abort to the REQ-025 values; the sequence restarts from edge 1 after deassertion.

Verification
REQ-027 Defaults, release rstz, sw_req=0 -> stage_rstz goes 000->001 at edge 24, 011 at edge 40, 111 at edge 56; ready=1 at edge 56; done high only in the cycle after edge 56.
REQ-028 In RUN, sw_req=1 for one cycle -> next edge: stage_rstz=000, ready=0, busy=1; stage0 re-releases 24 edges after sw_req drops.
REQ-029 sw_req held high 10 cycles at edge 30 (stage0 released) -> stage_rstz=000 throughout; full 24/40/56 sequence counted from the sw_req falling edge.
REQ-030 rstz pulsed low asynchronously between clock edges at edge 45 -> outputs 0 immediately, without waiting for a clock edge; the sequence restarts on deassertion.
REQ-031 NSTAGE=1, HOLD=1, DELAY=1 -> stage_rstz[0], ready, and done rise at edge 2; no counter overflow.
